// File: rtl/ahbvga_arb_pkg.sv
// Shared types and AHB encodings for the VGA console write arbiter.
package ahbvga_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } arb_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module rr_arbiter2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1
);

    always_comb begin
        gnt0 = valid0 && (!valid1 || last_grant);
        gnt1 = valid1 && !gnt0;
    end

endmodule

// File: rtl/ahbvga_write_arbiter.sv
// AHB-Lite master writing one character per grant to the VGA console data register.
// Optional feature: define ARB_TIMEOUT_EN for a sticky data-phase wait timeout flag.
module ahbvga_write_arbiter
    import ahbvga_arb_pkg::*;
#(
    parameter logic [31:0] VGA_BASE = 32'h5000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        busy,
    output logic [15:0] tx_count,
    output logic        timeout_err
);

    arb_state_e  state_q, state_d;
    logic [7:0]  char_q, char_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [15:0] tx_count_q, tx_count_d;
    logic        gnt0, gnt1;

    rr_arbiter2 u_rr (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    always_comb begin
        state_d      = state_q;
        char_d       = char_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        hwdata_d     = hwdata_q;
        tx_count_d   = tx_count_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gnt0 || gnt1) begin
                    req0_ready = gnt0;
                    req1_ready = gnt1;
                    char_d     = gnt1 ? req1_data : req0_data;
                    grant_d    = gnt1;
                    state_d    = StAddr;
                end
            end
            StAddr: begin
                // Load write data as the address phase completes so it is valid for the data phase.
                if (HREADY) begin
                    hwdata_d = {24'h0, char_q};
                    state_d  = StData;
                end
            end
            StData: begin
                if (HREADY) begin
                    tx_count_d   = tx_count_q + 16'd1;
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= StIdle;
            char_q       <= 8'h0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            hwdata_q     <= 32'h0;
            tx_count_q   <= 16'h0;
        end else begin
            state_q      <= state_d;
            char_q       <= char_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            hwdata_q     <= hwdata_d;
            tx_count_q   <= tx_count_d;
        end
    end

    assign HTRANS   = (state_q == StAddr) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HWRITE   = (state_q == StAddr);
    assign HADDR    = (state_q == StIdle) ? 32'h0 : VGA_BASE;
    assign HSIZE    = HSIZE_WORD;
    assign HWDATA   = hwdata_q;
    assign busy     = (state_q != StIdle);
    assign tx_count = tx_count_q;

    // A zero limit would flag on the first wait cycle; kept legal but visible here.
    if (TIMEOUT == 0) begin : g_timeout_zero
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    always_comb begin
        wait_cnt_d    = 16'h0;
        timeout_err_d = timeout_err_q;
        if (state_q == StData && !HREADY) begin
            wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
            if (({1'b0, wait_cnt_q} + 17'd1) >= 17'(TIMEOUT)) begin
                timeout_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wait_cnt_q    <= 16'h0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ahbvga_write_arbiter.sv
// Self-checking bench for ahbvga_write_arbiter: directed cases plus random traffic vs a transfer-level model.
module tb_ahbvga_write_arbiter;

    localparam logic [31:0] VGA_BASE = 32'h5000_0000;
    localparam int unsigned TIMEOUT  = 16;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, busy, timeout_err;
    logic [2:0]  HSIZE;
    logic [15:0] tx_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 HCLK = ~HCLK;

    ahbvga_write_arbiter #(
        .VGA_BASE (VGA_BASE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HWDATA      (HWDATA),
        .HREADY      (HREADY),
        .busy        (busy),
        .tx_count    (tx_count),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Transfer-level model: pending character, bus phase (0 none, 1 address, 2 data).
    int          m_phase;
    logic        m_last, m_gnt, m_err;
    logic [7:0]  m_char;
    logic [31:0] m_hwdata;
    logic [15:0] m_count;
    int          m_low;
    logic        model_on = 1'b0;
    logic        s_acc0, s_acc1;

    task automatic model_reset();
        m_phase = 0; m_last = 1'b1; m_gnt = 1'b0; m_err = 1'b0;
        m_char = 8'h0; m_hwdata = 32'h0; m_count = 16'h0; m_low = 0;
    endtask

    always @(negedge HCLK) begin
        logic e0, e1;
        s_acc0 = req0_valid && req0_ready;
        s_acc1 = req1_valid && req1_ready;
        if (model_on && HRESETn) begin
            e0 = 1'b0;
            e1 = 1'b0;
            if (m_phase == 0) begin
                if (req0_valid && req1_valid) begin
                    e0 = m_last;
                    e1 = !m_last;
                end else begin
                    e0 = req0_valid;
                    e1 = req1_valid;
                end
            end
            check("ready0", req0_ready, e0);
            check("ready1", req1_ready, e1);
            check("busy", busy, m_phase != 0);
            check("htrans", HTRANS, (m_phase == 1) ? 2'b10 : 2'b00);
            check("hsize", HSIZE, 3'b010);
            check("hwdata", HWDATA, m_hwdata);
            check("tx_count", tx_count, m_count);
            check("timeout_err", timeout_err, m_err);
            if (m_phase != 0) begin
                check("haddr", HADDR, VGA_BASE);
                check("hwrite", HWRITE, m_phase == 1);
            end
            case (m_phase)
                0: if (e0 || e1) begin
                    m_char  = e1 ? req1_data : req0_data;
                    m_gnt   = e1;
                    m_phase = 1;
                end
                1: if (HREADY) begin
                    m_hwdata = {24'h0, m_char};
                    m_phase  = 2;
                end
                default: if (HREADY) begin
                    m_count = m_count + 16'd1;
                    m_last  = m_gnt;
                    m_phase = 0;
                end else begin
                    m_low++;
`ifdef ARB_TIMEOUT_EN
                    if (m_low >= TIMEOUT) m_err = 1'b1;
`endif
                end
            endcase
            if (m_phase != 2) m_low = 0;
            if (m_phase == 2 && HREADY) m_low = 0;
        end
    end

    // Random requester/slave behaviour; held characters may be withdrawn while ungranted.
    logic rand_on = 1'b0;
    always @(posedge HCLK) begin
        if (rand_on) begin
            #1;
            if (req0_valid && !s_acc0) begin
                if ($urandom_range(9) == 0) req0_valid = 1'b0;
            end else begin
                req0_valid = ($urandom_range(9) < 6);
                req0_data  = 8'($urandom);
            end
            if (req1_valid && !s_acc1) begin
                if ($urandom_range(9) == 0) req1_valid = 1'b0;
            end else begin
                req1_valid = ($urandom_range(9) < 6);
                req1_data  = 8'($urandom);
            end
            HREADY = ($urandom_range(3) != 0);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge HCLK);
        while (busy && n < 60) begin
            @(negedge HCLK);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic send(input logic id, input logic [7:0] ch);
        @(posedge HCLK); #1;
        if (id) begin req1_valid = 1'b1; req1_data = ch; end
        else begin req0_valid = 1'b1; req0_data = ch; end
        @(posedge HCLK); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        logic [6:0] pat;
        logic [7:0] tie_exp;
        HRESETn = 1'b0; HREADY = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h0; req1_data = 8'h0;
        model_reset();
        repeat (2) @(posedge HCLK);
        #2;
        check("rst_htrans", HTRANS, 2'b00);
        check("rst_hwrite", HWRITE, 1'b0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hwdata", HWDATA, 32'h0);
        check("rst_hsize", HSIZE, 3'b010);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_count", tx_count, 16'h0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_ready", {req0_ready, req1_ready}, 2'b00);
        @(posedge HCLK); #1;
        HRESETn  = 1'b1;
        model_on = 1'b1;

        // Tie from reset: req0 first, alternating, one write per 3 cycles.
        @(posedge HCLK); #1;
        req0_valid = 1'b1; req0_data = 8'h10;
        req1_valid = 1'b1; req1_data = 8'h20;
        for (int k = 0; k < 4; k++) begin
            tie_exp = (k % 2 == 0) ? 8'h10 : 8'h20;
            @(negedge HCLK);
            check("tie_grant0", req0_ready, k % 2 == 0);
            @(negedge HCLK);
            check("tie_addr", HTRANS, 2'b10);
            @(negedge HCLK);
            check("tie_data", HWDATA, {24'h0, tie_exp});
        end
        @(posedge HCLK); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        check("tie_count", tx_count, 16'd4);

        // Single write with fixed latency.
        @(posedge HCLK); #1;
        req0_valid = 1'b1; req0_data = 8'h41;
        @(negedge HCLK);
        check("single_ready", req0_ready, 1'b1);
        @(posedge HCLK); #1;
        req0_valid = 1'b0;
        @(negedge HCLK);
        check("single_haddr", HADDR, VGA_BASE);
        check("single_htrans", HTRANS, 2'b10);
        @(negedge HCLK);
        check("single_hwdata", HWDATA, 32'h41);
        @(negedge HCLK);
        check("single_count", tx_count, 16'd5);

        // Wait states: 2 in address phase, 3 in data phase -> 8 cycles total.
        pat = 7'b1000100;
        @(posedge HCLK); #1;
        req1_valid = 1'b1; req1_data = 8'h5A; HREADY = 1'b0;
        @(negedge HCLK);
        check("ws_ready", req1_ready, 1'b1);
        for (int i = 0; i < 7; i++) begin
            @(posedge HCLK); #1;
            req1_valid = 1'b0;
            HREADY = pat[i];
            @(negedge HCLK);
            if (i < 3) begin
                check("ws_addr_htrans", HTRANS, 2'b10);
                check("ws_addr_haddr", HADDR, VGA_BASE);
            end else begin
                check("ws_data_hwdata", HWDATA, 32'h5A);
            end
        end
        @(negedge HCLK);
        check("ws_done", busy, 1'b0);
        HREADY = 1'b1;

        // Counter wrap.
        @(posedge HCLK); #1;
        force dut.tx_count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        #1 release dut.tx_count_q;
        send(1'b1, 8'h7E);
        check("wrap_count", tx_count, 16'h0);

        // Random traffic.
        rand_on = 1'b1;
        repeat (1500) @(posedge HCLK);
        rand_on = 1'b0;
        @(posedge HCLK); #2;
        req0_valid = 1'b0; req1_valid = 1'b0; HREADY = 1'b1;
        wait_idle();

        // Data-phase wait of exactly TIMEOUT cycles.
        @(posedge HCLK); #1;
        req0_valid = 1'b1; req0_data = 8'h55;
        @(posedge HCLK); #1;
        req0_valid = 1'b0;
        @(posedge HCLK); #1;
        HREADY = 1'b0;
        repeat (TIMEOUT) @(posedge HCLK);
        #1 HREADY = 1'b1;
        @(negedge HCLK);
`ifdef ARB_TIMEOUT_EN
        check("timeout_set", timeout_err, 1'b1);
`else
        check("timeout_off", timeout_err, 1'b0);
`endif
        check("timeout_still_busy", busy, 1'b1);
        wait_idle();
`ifdef ARB_TIMEOUT_EN
        check("timeout_sticky", timeout_err, 1'b1);
`else
        check("timeout_off_after", timeout_err, 1'b0);
`endif

        // Reset in the middle of a data phase.
        @(posedge HCLK); #1;
        req0_valid = 1'b1; req0_data = 8'h99; HREADY = 1'b0;
        @(posedge HCLK); #1;
        req0_valid = 1'b0; HREADY = 1'b1;
        @(posedge HCLK); #1;
        HREADY = 1'b0;
        @(negedge HCLK);
        #2 HRESETn = 1'b0;
        #1;
        check("mid_rst_htrans", HTRANS, 2'b00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_count", tx_count, 16'h0);
        check("mid_rst_hwdata", HWDATA, 32'h0);
        check("mid_rst_timeout_err", timeout_err, 1'b0);
        model_reset();
        HREADY = 1'b1;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        send(1'b1, 8'h33);
        check("post_rst_count", tx_count, 16'd1);
        check("post_rst_hwdata", HWDATA, 32'h33);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
